mdu_sequencer: RTL and testbench
================================

// Module: mdu_sequencer
// PURPOSE
//   Multiply/divide unit with HI/LO registers and a cycle-accurate busy sequencer, in the E stage.
//   Produces the start/busy pair the D-stage control unit uses to stall mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
//   Operation results are computed at issue, held in shadow registers and committed to HI/LO when the latency expires.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (1..15)
//   DIV_CYCLES   10  busy cycles for div/divu (1..15)
// PORTS
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-high reset
//   start        in   1   issue strobe from E stage, one cycle, only with md_op = MULT/MULTU/DIV/DIVU
//   md_op        in   3   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NONE
//   rs_data      in   32  operand A (forwarded rs), also the mthi/mtlo source
//   rt_data      in   32  operand B (forwarded rt)
//   rd_sel       in   1   0 selects LO, 1 selects HI for mflo/mfhi
//   busy         out  1   operation in flight
//   hi           out  32  architectural HI
//   lo           out  32  architectural LO
//   rd_data      out  32  combinational: rd_sel ? hi : lo
// BEHAVIOUR
//   Reset (asynchronous, any state): busy=0, hi=0, lo=0, cnt=0, shadow regs=0, state=IDLE.
//     Reset during RUN discards the pending result.
//   States: IDLE, RUN. cnt is 4 bits.
//   IDLE, start=1 with md_op MULT/MULTU/DIV/DIVU:
//     - latch shadow results on that edge.
//     - MULT: signed 64-bit product; {sh_hi, sh_lo} = $signed(A)*$signed(B).
//     - MULTU: unsigned 64-bit product.
//     - DIV: sh_lo = signed quotient, sh_hi = signed remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
//     - DIVU: unsigned quotient and remainder.
//     - DIV/DIVU with B==0: shadow <= current hi/lo, so HI/LO are left unchanged at commit; busy sequence still runs.
//     - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
//     - cnt <= latency-1; busy <= 1 on the same edge; state RUN.
//     - busy is high for exactly latency cycles after the issue edge.
//   RUN: cnt decrements each cycle. On the edge where cnt==0:
//     - hi<=sh_hi, lo<=sh_lo, busy<=0, state IDLE.
//     - New HI/LO are visible to an mfhi/mflo in E on the cycle busy first reads 0.
//   IDLE, md_op MTHI (no start): hi<=rs_data next edge; lo unchanged. MTLO: lo<=rs_data; hi unchanged.
//   start=1 with md_op MTHI/MTLO/NONE/7 is treated as MTHI/MTLO/NONE; no sequence starts.
//   Illegal while busy (the CU stall guarantees these never occur):
//     - start and MTHI/MTLO are ignored; state, cnt and HI/LO are unchanged.
//     - Simulation-only assertion fires.
//   start and busy never overlap. CU stall term is (start|busy) & md-class instr in D.
//   rd_data is purely combinational from hi/lo/rd_sel; no extra latency.
// TESTING
//   mult A=0xFFFFFFFE(-2), B=3, start 1 cycle -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//   multu A=0xFFFFFFFF, B=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
//   div A=-7(0xFFFFFFF9), B=2 -> busy 10 cycles; lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//   divu A=7, B=0 with hi=0x11, lo=0x22 -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
//   mthi rs=0xDEADBEEF in IDLE -> hi=0xDEADBEEF next edge, lo unchanged, busy stays 0; rd_sel=1 -> rd_data=0xDEADBEEF.
//   divu issued, reset asserted asynchronously at busy cycle 4 -> busy, hi, lo read 0 immediately; no commit after reset releases.

Source files
------------

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: E-stage <-> multiply/divide unit bundle.
//   start   : one-cycle issue strobe (mult/multu/div/divu only)
//   md_op   : 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   rs_data : operand A, also mthi/mtlo source
//   rt_data : operand B
//   rd_sel  : 0 LO, 1 HI for mflo/mfhi
//   busy    : operation in flight
//   hi, lo  : architectural HI/LO
//   rd_data : rd_sel ? hi : lo (combinational)
// master = E-stage driver, slave = the unit.
interface mdu_sequencer_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rd_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output start, md_op, rs_data, rt_data, rd_sel,
    input  busy, hi, lo, rd_data
  );

  modport slave (
    input  start, md_op, rs_data, rt_data, rd_sel,
    output busy, hi, lo, rd_data
  );
endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multiply/divide unit with HI/LO and a cycle-accurate busy
// sequencer. Results are computed at issue into shadow registers and
// committed to HI/LO on the edge the latency counter expires, so the
// decode-stage stall logic only has to watch start|busy.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   md    : mdu_sequencer_if.slave (issue, operands, HI/LO read port)
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,   // 1..15
  parameter int DIV_CYCLES  = 10   // 1..15
) (
  input  logic           clk,
  input  logic           reset,
  mdu_sequencer_if.slave md
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LAT_M1 = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LAT_M1  = 4'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;

  // ---------------- issue-time datapath ----------------
  logic [31:0]        a, b, b_safe;
  logic signed [63:0] a_sx, b_sx, prod_s;
  logic [63:0]        prod_u;
  logic               div_zero, div_ovf;
  logic signed [31:0] q_s, r_s;
  logic [31:0]        q_u, r_u;

  assign a    = md.rs_data;
  assign b    = md.rt_data;
  assign a_sx = {{32{a[31]}}, a};
  assign b_sx = {{32{b[31]}}, b};

  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'b0, a} * {32'b0, b};

  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  // Divide by 1 instead of 0 or -1 in the two corner cases: the zero case is
  // overridden below, and for MIN/-1 dividing by 1 yields exactly the wrapped
  // answer (q = 0x80000000, r = 0) without a signed-overflow divide.
  assign b_safe = (div_zero || div_ovf) ? 32'd1 : b;

  assign q_s = $signed(a) / $signed(b_safe);
  assign r_s = $signed(a) % $signed(b_safe);
  assign q_u = a / b_safe;
  assign r_u = a % b_safe;

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;

    case (state_q)
      IDLE: begin
        if (md.start && (md.md_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU})) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = (md.md_op inside {OP_MULT, OP_MULTU}) ? MULT_LAT_M1 : DIV_LAT_M1;
          case (md.md_op)
            OP_MULT:  {sh_hi_d, sh_lo_d} = prod_s;
            OP_MULTU: {sh_hi_d, sh_lo_d} = prod_u;
            // Divide by zero re-commits the current HI/LO, i.e. no change.
            OP_DIV:   {sh_hi_d, sh_lo_d} = div_zero ? {hi_q, lo_q} : {r_s, q_s};
            default:  {sh_hi_d, sh_lo_d} = div_zero ? {hi_q, lo_q} : {r_u, q_u};
          endcase
        end else if (md.md_op == OP_MTHI) begin
          hi_d = a;
        end else if (md.md_op == OP_MTLO) begin
          lo_d = a;
        end
      end
      RUN: begin
        // start/mthi/mtlo are ignored here; the stall logic keeps them out.
        if (cnt_q == 4'd0) begin
          hi_d    = sh_hi_q;
          lo_d    = sh_lo_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign md.busy    = busy_q;
  assign md.hi      = hi_q;
  assign md.lo      = lo_q;
  assign md.rd_data = md.rd_sel ? hi_q : lo_q;

  // Nothing that touches HI/LO may arrive while a sequence is in flight.
  a_no_issue_when_busy: assert property (@(posedge clk) disable iff (reset)
    busy_q |-> !(md.start || md.md_op == OP_MTHI || md.md_op == OP_MTLO));

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed + randomized bench for mdu_sequencer against
// an arithmetic reference model of HI/LO (64-bit longint math).
module tb_mdu_sequencer;
  logic clk;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [31:0] hi_m, lo_m;

  mdu_sequencer_if mif();

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .md   (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: HI/LO effect of one operation, from plain arithmetic.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd2: begin pu = {32'b0, a} * {32'b0, b}; hi_m = pu[63:32]; lo_m = pu[31:0]; end
      3'd3: if (b != 0) begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
      3'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      3'd5: hi_m = a;
      3'd6: lo_m = a;
      default: ;
    endcase
  endtask

  function automatic int latency(input logic [2:0] op);
    return (op == 3'd1 || op == 3'd2) ? 5 : 10;
  endfunction

  // Issue a sequenced op and follow it to commit.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [31:0] ohi, olo;
    @(negedge clk);
    mif.start = 1'b1; mif.md_op = op; mif.rs_data = a; mif.rt_data = b;
    mif.rd_sel = 1'($urandom_range(0, 1));
    ohi = hi_m; olo = lo_m;
    model_op(op, a, b);
    @(negedge clk);
    mif.start = 1'b0; mif.md_op = 3'd0; mif.rs_data = $urandom; mif.rt_data = $urandom;
    chk("hi_hold", mif.hi, ohi);
    chk("lo_hold", mif.lo, olo);
    n = 0;
    while (mif.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, latency(op));
    chk("hi", mif.hi, hi_m);
    chk("lo", mif.lo, lo_m);
    chk("rd_data", mif.rd_data, mif.rd_sel ? hi_m : lo_m);
  endtask

  // Non-sequenced op (MTHI/MTLO/NONE/7), optionally with a stray start.
  task automatic simple(input logic [2:0] op, input logic [31:0] a, input logic st);
    @(negedge clk);
    mif.start = st; mif.md_op = op; mif.rs_data = a; mif.rt_data = $urandom;
    mif.rd_sel = 1'($urandom_range(0, 1));
    model_op(op, a, 32'd0);
    @(negedge clk);
    mif.start = 1'b0; mif.md_op = 3'd0;
    chk("mt_busy", mif.busy, 1'b0);
    chk("mt_hi", mif.hi, hi_m);
    chk("mt_lo", mif.lo, lo_m);
    chk("mt_rd", mif.rd_data, mif.rd_sel ? hi_m : lo_m);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int sel;
    reset = 1'b1;
    mif.start = 1'b0; mif.md_op = 3'd0; mif.rs_data = '0; mif.rt_data = '0; mif.rd_sel = 1'b0;
    hi_m = '0; lo_m = '0;
    #1;
    chk("rst_busy", mif.busy, 1'b0);
    chk("rst_hi", mif.hi, 32'd0);
    chk("rst_lo", mif.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    chk("mult_hi", mif.hi, 32'hFFFF_FFFF);
    chk("mult_lo", mif.lo, 32'hFFFF_FFFA);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hi", mif.hi, 32'h0000_0001);
    chk("multu_lo", mif.lo, 32'hFFFF_FFFE);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    chk("div_hi", mif.hi, 32'hFFFF_FFFF);
    chk("div_lo", mif.lo, 32'hFFFF_FFFD);
    simple(3'd5, 32'h11, 1'b0);
    simple(3'd6, 32'h22, 1'b0);
    issue(3'd4, 32'd7, 32'd0);
    chk("div0_hi", mif.hi, 32'h11);
    chk("div0_lo", mif.lo, 32'h22);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_hi", mif.hi, 32'd0);
    chk("ovf_lo", mif.lo, 32'h8000_0000);
    simple(3'd5, 32'hDEAD_BEEF, 1'b0);
    mif.rd_sel = 1'b1;
    #1 chk("mthi_rd", mif.rd_data, 32'hDEAD_BEEF);
    simple(3'd6, 32'h1234_5678, 1'b1);
    simple(3'd7, 32'hFFFF_0000, 1'b1);

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = $urandom_range(1, 9);
        default: ;
      endcase
      if (sel <= 3 || sel >= 8) begin
        op = 3'(1 + (sel % 4));
        issue(op, a, b);
      end else begin
        op = (sel == 4) ? 3'd5 : (sel == 5) ? 3'd6 : (sel == 6) ? 3'd0 : 3'd7;
        simple(op, a, 1'($urandom_range(0, 1)));
      end
    end

    // Asynchronous reset mid-sequence discards the pending result
    @(negedge clk);
    mif.start = 1'b1; mif.md_op = 3'd4; mif.rs_data = 32'd100; mif.rt_data = 32'd7;
    @(negedge clk);
    mif.start = 1'b0; mif.md_op = 3'd0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", mif.busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    hi_m = '0; lo_m = '0;
    chk("arst_busy", mif.busy, 1'b0);
    chk("arst_hi", mif.hi, 32'd0);
    chk("arst_lo", mif.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) begin
      @(negedge clk);
      chk("post_busy", mif.busy, 1'b0);
    end
    chk("post_hi", mif.hi, hi_m);
    chk("post_lo", mif.lo, lo_m);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
